timer_tick_scheduler: RTL
=========================

Name: timer_tick_scheduler

Overview:
- Avalon-MM master that programs and services the 16-bit-register interval timer: period lo/hi at addr 2/3, control at addr 1, status at addr 0.
- Converts each timer timeout IRQ into a one-cycle base tick.
- Divides that tick into NUM_CH independent periodic software channels, each with its own expire pulse.
- Used by the temperature-control fabric to schedule sensor sampling, PID update and display refresh from one hardware timer.

Parameters:
- NUM_CH, 4: number of software channels (1..8).
- CH_W, 16: width of each channel reload/count value.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin programming and running the timer
- stop  in  1  pulse; halt the timer and the scheduler
- cfg_period  in  32  timer period in clk cycles minus one; sampled on start
- ch_en  in  NUM_CH  per-channel enable
- ch_reload  in  NUM_CH*CH_W  per-channel tick divisor; channel i uses bits [i*CH_W +: CH_W]
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer chip select
- tmr_write_n  out  1  timer write strobe, active low
- tmr_writedata  out  16  timer write data
- tmr_irq  in  1  timer interrupt, level, held until status is written
- busy  out  1  high in every state except IDLE
- tick  out  1  one-cycle pulse per serviced timeout
- ch_expire  out  NUM_CH  one-cycle pulse per channel expiry

Behaviour:
- Reset values: state IDLE; tmr_chipselect 0; tmr_write_n 1; tmr_address 0; tmr_writedata 0; tick 0; ch_expire 0; busy 0; all channel counters 0; latched period 0.
- All master outputs are registered. Each write is one cycle: chipselect=1, write_n=0. There is no waitrequest.

State machine and transitions:
- IDLE: on start, latch cfg_period, go to WR_PL. stop is ignored in IDLE.
- WR_PL: write addr 2 = period[15:0]. Next state WR_PH.
- WR_PH: write addr 3 = period[31:16]. Next state WR_CTRL.
- WR_CTRL: write addr 1 = 16'h0007 (START|CONT|ITO). Next state RUN.
- RUN: bus idle.
  - If stop: go to WR_STOP. stop takes priority over tmr_irq in the same cycle.
  - Else if tmr_irq: go to CLR.
- CLR: write addr 0 = 0 to clear timeout. Next state TICK.
- TICK: tick=1 for this cycle; channel update happens here; return to RUN.
  - tmr_irq has already dropped by RUN re-entry, so one timeout yields exactly one tick.
- WR_STOP: write addr 1 = 16'h0008 (STOP, interrupts disabled). Next state WR_ACK.
- WR_ACK: write addr 0 = 0 to discard any pending timeout. Next state IDLE.

Latency and start/stop rules:
- Latency from start to timer running is 3 cycles (3 writes).
- Latency from IRQ assertion to tick is 2 cycles.
- start outside IDLE is ignored.
- stop during WR_PL, WR_PH, WR_CTRL, CLR or TICK is remembered in a pending flag. It is acted on at the next RUN entry (RUN goes directly to WR_STOP).

Channel counters (per channel i, width CH_W):
- While ch_en[i]=0: counter held at ch_reload[i]; no expire.
- On each TICK with ch_en[i]=1:
  - reload=0: channel never expires; counter unchanged.
  - counter <= 1: ch_expire[i]=1 in that TICK cycle; counter <= reload.
  - otherwise: counter decrements by 1.
- Result: with reload=R, the first expire occurs on the R-th tick after enable, then every R ticks.
- Changing ch_reload while enabled takes effect at the next expiry.
- On stop completion, counters reload from ch_reload.

Reset:
- Reset mid-sequence returns to IDLE immediately.
- The timer itself is reset by the same reset_n, so no cleanup writes are required.

Optional Feature:
- Macro: TIMER_TICK_COUNT_EN.
- With the macro defined:
  - Adds output tick_count [31:0], reset 0.
  - Increments on each TICK and wraps 32'hFFFFFFFF -> 0.
  - Cleared on each start accepted in IDLE.
- Without the macro: the port and register are absent.

Decomposition:
- Package timer_sched_pkg contains:
  - State enum.
  - Timer register address constants: STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3.
  - Control bit constants: ITO=0, CONT=1, START=2, STOP=3.
  - Write-data constants CTRL_RUN=16'h0007, CTRL_STOP=16'h0008.
- One sub-module, tick_channel: a single channel counter (en, reload, tick -> expire), instantiated NUM_CH times by generate.

Test Plan:
- Start with cfg_period=32'h0001_86A0 -> bus writes, one per cycle:
  - addr2 = 16'h86A0
  - addr3 = 16'h0001
  - addr1 = 16'h0007
  - then busy=1 and the state is RUN.
- Timer model with period 49 -> one tick every 50 cycles, each 2 cycles after irq rises. Exactly one addr0 write per irq; no double ticks.
- Channel reloads {1,2,3,0} over 6 ticks ->
  - ch0 expires on all 6 ticks
  - ch1 expires on ticks 2, 4 and 6
  - ch2 expires on ticks 3 and 6
  - ch3 never expires
- stop asserted in the same cycle as irq in RUN -> writes addr1=16'h0008 then addr0=0, then IDLE; no tick.
- stop pulsed during WR_PH -> WR_CTRL completes, then RUN, then the stop sequence follows; busy falls 3 cycles after RUN entry.
- reset_n deasserted mid-CLR -> all outputs return to reset values asynchronously. A following start reprograms the timer correctly.
  - With TIMER_TICK_COUNT_EN defined: tick_count=0 after 0xFFFFFFFF wrap.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: scheduler states, interval-timer register map and control words.
package timer_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR,
        TICK,
        WR_STOP,
        WR_ACK
    } state_t;

    localparam logic [2:0] STATUS  = 3'd0;
    localparam logic [2:0] CONTROL = 3'd1;
    localparam logic [2:0] PERIODL = 3'd2;
    localparam logic [2:0] PERIODH = 3'd3;

    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    localparam logic [15:0] CTRL_RUN  = 16'((1 << START) | (1 << CONT) | (1 << ITO));
    localparam logic [15:0] CTRL_STOP = 16'(1 << STOP);

endpackage

// File: rtl/timer_tick_scheduler_tick_channel.sv
// tick_channel: one software channel dividing the base tick by its reload value.
module tick_channel #(
    parameter int CH_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [CH_W-1:0] reload,
    input  logic            step,
    input  logic            load,
    output logic            expire
);

    logic [CH_W-1:0] cnt;
    logic            hit;

    // step arrives one cycle ahead of the TICK state so expire lines up with tick
    assign hit = step && en && (reload != '0) && (cnt <= CH_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else begin
            expire <= hit;
            if (load || !en)
                cnt <= reload;
            else if (step && reload != '0)
                cnt <= hit ? reload : cnt - CH_W'(1);
        end
    end

endmodule

// File: rtl/timer_tick_scheduler.sv
// timer_tick_scheduler: programs/services an Avalon interval timer and divides its tick into NUM_CH channels.
// Define TIMER_TICK_COUNT_EN to add the free-running tick_count output.
module timer_tick_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [31:0]            cfg_period,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [NUM_CH*CH_W-1:0] ch_reload,
    output logic [2:0]             tmr_address,
    output logic                   tmr_chipselect,
    output logic                   tmr_write_n,
    output logic [15:0]            tmr_writedata,
    input  logic                   tmr_irq,
    output logic                   busy,
    output logic                   tick,
    output logic [NUM_CH-1:0]      ch_expire
`ifdef TIMER_TICK_COUNT_EN
    ,
    output logic [31:0]            tick_count
`endif
);

    state_t      state;
    logic [15:0] period_hi;
    logic        stop_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            period_hi      <= '0;
            stop_pend      <= 1'b0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= '0;
            tmr_writedata  <= '0;
            tick           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tick           <= 1'b0;
            // a stop seen mid-sequence is deferred to the next RUN entry
            if (stop && state inside {WR_PL, WR_PH, WR_CTRL, CLR, TICK})
                stop_pend <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    period_hi      <= cfg_period[31:16];
                    stop_pend      <= 1'b0;
                    busy           <= 1'b1;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= PERIODL;
                    tmr_writedata  <= cfg_period[15:0];
                    state          <= WR_PL;
                end
                WR_PL: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= PERIODH;
                    tmr_writedata  <= period_hi;
                    state          <= WR_PH;
                end
                WR_PH: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= CONTROL;
                    tmr_writedata  <= CTRL_RUN;
                    state          <= WR_CTRL;
                end
                WR_CTRL: state <= RUN;
                RUN: if (stop || stop_pend) begin
                    stop_pend      <= 1'b0;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= CONTROL;
                    tmr_writedata  <= CTRL_STOP;
                    state          <= WR_STOP;
                end else if (tmr_irq) begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= STATUS;
                    tmr_writedata  <= '0;
                    state          <= CLR;
                end
                CLR: begin
                    tick  <= 1'b1;
                    state <= TICK;
                end
                TICK: state <= RUN;
                WR_STOP: begin
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_address    <= STATUS;
                    tmr_writedata  <= '0;
                    state          <= WR_ACK;
                end
                WR_ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(.CH_W(CH_W)) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (ch_en[i]),
            .reload (ch_reload[i*CH_W +: CH_W]),
            .step   (state == CLR),
            .load   (state == WR_ACK),
            .expire (ch_expire[i])
        );
    end

`ifdef TIMER_TICK_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tick_count <= '0;
        else if (state == IDLE && start)
            tick_count <= '0;
        else if (state == CLR)
            tick_count <= tick_count + 32'd1;
    end
`endif

endmodule
